// File: rtl/sobel_edge_core.sv
// sobel_edge_core: streaming 3x3 Sobel edge detector with thresholded binary output
//   InPixClk, InRst                 : pixel clock, synchronous active-high reset
//   InPicDe, InPicClr, InPicData    : raster gray stream, one-cycle frame-start pulse
//   OutPicDe, OutPicClr, OutPicData : edge stream (value replicated on IMAGE_C channels), Clr delayed 3
module sobel_edge_core #(
    parameter int IMAGE_W   = 192,
    parameter int IMAGE_H   = 108,
    parameter int IMAGE_DW  = 8,
    parameter int IMAGE_C   = 3,
    parameter int THRESHOLD = 128
) (
    input  logic                        InPixClk,
    input  logic                        InRst,
    input  logic                        InPicDe,
    input  logic                        InPicClr,
    input  logic [IMAGE_DW-1:0]         InPicData,
    output logic                        OutPicDe,
    output logic                        OutPicClr,
    output logic [IMAGE_DW*IMAGE_C-1:0] OutPicData
);
    localparam int CW = $clog2(IMAGE_W);
    localparam int RW = $clog2(IMAGE_H);
    localparam int GW = IMAGE_DW + 3;
    localparam logic [CW-1:0] C_LAST = CW'(IMAGE_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMAGE_H - 1);
    localparam logic [GW-1:0] THR = GW'(THRESHOLD);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t                state;
    logic [CW-1:0]         in_col, out_col;
    logic [RW-1:0]         in_row, out_row;
    logic [IMAGE_DW-1:0]   lb1 [IMAGE_W];
    logic [IMAGE_DW-1:0]   lb2 [IMAGE_W];
    // taps p00..p22 in row-major order; column 2 is the newest
    logic [IMAGE_DW-1:0]   win [9];
    logic                  v1, b1, v2, b2;
    logic signed [GW-1:0]  gx, gy, gx_c, gy_c;
    logic [GW-1:0]         mag;
    logic [IMAGE_DW-1:0]   edge_px;
    logic [1:0]            clr_d;
    logic                  accept, launch, in_last, out_last, border;

    function automatic logic signed [GW-1:0] ext(input logic [IMAGE_DW-1:0] p);
        return $signed(GW'(p));
    endfunction

    function automatic logic [GW-1:0] absv(input logic signed [GW-1:0] v);
        return v[GW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    assign accept   = !InPicClr && InPicDe && (state == FILL || state == RUN);
    assign launch   = !InPicClr && (state == FLUSH || (state == RUN && InPicDe));
    assign in_last  = in_row == R_LAST && in_col == C_LAST;
    assign out_last = out_row == R_LAST && out_col == C_LAST;
    // the launch counters track the centre pixel, so the border test needs no taps
    assign border   = out_row == '0 || out_row == R_LAST || out_col == '0 || out_col == C_LAST;

    always_comb begin
        gx_c = (ext(win[2]) + (ext(win[5]) <<< 1) + ext(win[8])) -
               (ext(win[0]) + (ext(win[3]) <<< 1) + ext(win[6]));
        gy_c = (ext(win[6]) + (ext(win[7]) <<< 1) + ext(win[8])) -
               (ext(win[0]) + (ext(win[1]) <<< 1) + ext(win[2]));
        mag = absv(gx) + absv(gy);
        edge_px = (!b2 && mag > THR) ? {IMAGE_DW{1'b1}} : {IMAGE_DW{1'b0}};
    end

    // line buffers and window carry no reset: stale contents only ever reach border pixels
    always_ff @(posedge InPixClk) begin
        if (accept) begin
            lb1[in_col] <= InPicData;
            lb2[in_col] <= lb1[in_col];
            win <= '{win[1], win[2], lb2[in_col],
                     win[4], win[5], lb1[in_col],
                     win[7], win[8], InPicData};
        end
    end

    always_ff @(posedge InPixClk) begin
        if (InRst) begin
            state      <= IDLE;
            in_col     <= '0;
            in_row     <= '0;
            out_col    <= '0;
            out_row    <= '0;
            v1         <= 1'b0;
            b1         <= 1'b0;
            v2         <= 1'b0;
            b2         <= 1'b0;
            gx         <= '0;
            gy         <= '0;
            clr_d      <= '0;
            OutPicDe   <= 1'b0;
            OutPicClr  <= 1'b0;
            OutPicData <= '0;
        end else begin
            clr_d     <= {clr_d[0], InPicClr};
            OutPicClr <= clr_d[1];
            v1        <= launch;
            b1        <= border;
            v2        <= v1 && !InPicClr;
            b2        <= b1;
            gx        <= gx_c;
            gy        <= gy_c;
            OutPicDe  <= v2 && !InPicClr;
            if (v2 && !InPicClr)
                OutPicData <= {IMAGE_C{edge_px}};
            if (InPicClr) begin
                state   <= FILL;
                in_col  <= '0;
                in_row  <= '0;
                out_col <= '0;
                out_row <= '0;
            end else begin
                if (accept) begin
                    in_col <= in_col == C_LAST ? '0 : in_col + 1'b1;
                    in_row <= in_col == C_LAST ? in_row + 1'b1 : in_row;
                end
                if (launch) begin
                    out_col <= out_col == C_LAST ? '0 : out_col + 1'b1;
                    out_row <= out_col == C_LAST ? out_row + 1'b1 : out_row;
                end
                case (state)
                    FILL:    if (accept && in_row == RW'(1) && in_col == '0) state <= RUN;
                    RUN:     if (accept && in_last) state <= FLUSH;
                    FLUSH:   if (out_last) state <= IDLE;
                    default: ;
                endcase
            end
        end
    end
endmodule
